tl45_operand_fetch: RTL and testbench

Parametrised register-read/operand-fetch stage of the tl45 pipeline, sitting between decode and execute. It reads two source operands from the DPRF and resolves busy registers through NFWD operand-forwarding buses. Unlike the fixed two-bus stage, it stalls decode on an unresolved hazard and inserts a bubble downstream. Operands resolved early are held in capture registers so transient forwarded data is not lost during a stall.

---
 rtl/tl45_operand_fetch.sv | 213 +++++++++++++++++++++
 tb/tb_tl45_operand_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl45_operand_fetch.sv
// tl45_operand_fetch
//   Register-read / operand-fetch stage between decode and execute.
//   Reads two source operands from the DPRF. A busy register is resolved from
//   one of NFWD forwarding buses; bus 0 has the highest priority. If an operand
//   cannot be resolved, decode is stalled and a bubble is sent downstream.
//   An operand that resolves while the instruction cannot advance is latched
//   into a capture register, so a forward that is only present for one cycle
//   is not lost.
//
// Ports
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_pipe_stall / o_pipe_stall    downstream stall in, upstream stall out
//   i_pipe_flush / o_pipe_flush    flush in, flush passed upstream
//   i_valid, i_opcode, i_ri, i_dr, i_sr1, i_sr2, i_imm32, i_pc
//                                  decode buffer contents
//   o_dprf_read_a1/a2, i_dprf_d1/d2
//                                  DPRF read ports (same-cycle data)
//   o_dprf_setbusy                 destination to mark busy (0 = none)
//   i_dprf_busylist                bit k = register k+1 busy
//   i_fwd_valid/reg/data           forwarding buses, bus n at slice n
//   o_valid, o_opcode, o_dr, o_sr1_val, o_sr2_val, o_pc
//                                  output buffer to execute
//   o_stall_cycles                 saturating count of hazard cycles
//
// Handshake: an instruction in the decode buffer (i_valid) moves into the
// output buffer on the clock edge where it is ready (both operands resolved)
// and i_pipe_stall is low. o_pipe_stall tells decode to hold its buffer.
// While i_pipe_stall is high, the output buffer holds its value.
module tl45_operand_fetch #(
  parameter int XLEN  = 32,
  parameter int NREGS = 16,
  parameter int NFWD  = 2,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_pipe_stall,
  output logic                 o_pipe_stall,
  input  logic                 i_pipe_flush,
  output logic                 o_pipe_flush,
  input  logic                 i_valid,
  input  logic [4:0]           i_opcode,
  input  logic                 i_ri,
  input  logic [RW-1:0]        i_dr,
  input  logic [RW-1:0]        i_sr1,
  input  logic [RW-1:0]        i_sr2,
  input  logic [XLEN-1:0]      i_imm32,
  input  logic [31:0]          i_pc,
  output logic [RW-1:0]        o_dprf_read_a1,
  output logic [RW-1:0]        o_dprf_read_a2,
  input  logic [XLEN-1:0]      i_dprf_d1,
  input  logic [XLEN-1:0]      i_dprf_d2,
  output logic [RW-1:0]        o_dprf_setbusy,
  input  logic [NREGS-2:0]     i_dprf_busylist,
  input  logic [NFWD-1:0]      i_fwd_valid,
  input  logic [NFWD*RW-1:0]   i_fwd_reg,
  input  logic [NFWD*XLEN-1:0] i_fwd_data,
  output logic                 o_valid,
  output logic [4:0]           o_opcode,
  output logic [RW-1:0]        o_dr,
  output logic [XLEN-1:0]      o_sr1_val,
  output logic [XLEN-1:0]      o_sr2_val,
  output logic [31:0]          o_pc,
  output logic [15:0]          o_stall_cycles
);

  // r0 is never busy. Prepending a zero lets the busy list be indexed directly
  // by register number.
  logic [NREGS-1:0] busy_full;

  logic            fwd1_hit, fwd2_hit;
  logic [XLEN-1:0] fwd1_val, fwd2_val;

  logic            cap1_flag, cap2_flag;
  logic [XLEN-1:0] cap1_val, cap2_val;

  logic            sr1_ok, sr2_ok;
  logic [XLEN-1:0] sr1_val, sr2_val;

  logic ready, hazard, advance;

  assign busy_full      = {i_dprf_busylist, 1'b0};
  assign o_dprf_read_a1 = i_sr1;
  assign o_dprf_read_a2 = i_sr2;
  assign o_pipe_flush   = i_pipe_flush;

  // Forward lookup. The scan runs from the highest bus down, so the lowest
  // matching bus is written last and wins.
  always_comb begin
    fwd1_hit = 1'b0;
    fwd1_val = '0;
    fwd2_hit = 1'b0;
    fwd2_val = '0;
    for (int n = NFWD - 1; n >= 0; n--) begin
      if (i_fwd_valid[n] && (i_fwd_reg[n*RW +: RW] == i_sr1)) begin
        fwd1_hit = 1'b1;
        fwd1_val = i_fwd_data[n*XLEN +: XLEN];
      end
      if (i_fwd_valid[n] && (i_fwd_reg[n*RW +: RW] == i_sr2)) begin
        fwd2_hit = 1'b1;
        fwd2_val = i_fwd_data[n*XLEN +: XLEN];
      end
    end
  end

  // Operand resolution in priority order. A captured value overrides
  // everything else, because the forward it came from may already be gone.
  always_comb begin
    sr1_ok  = 1'b0;
    sr1_val = '0;
    if (cap1_flag) begin
      sr1_ok  = 1'b1;
      sr1_val = cap1_val;
    end else if (i_sr1 == '0) begin
      sr1_ok  = 1'b1;
    end else if (!busy_full[i_sr1]) begin
      sr1_ok  = 1'b1;
      sr1_val = i_dprf_d1;
    end else if (fwd1_hit) begin
      sr1_ok  = 1'b1;
      sr1_val = fwd1_val;
    end
  end

  always_comb begin
    sr2_ok  = 1'b0;
    sr2_val = '0;
    if (i_ri) begin
      sr2_ok  = 1'b1;
      sr2_val = i_imm32;
    end else if (cap2_flag) begin
      sr2_ok  = 1'b1;
      sr2_val = cap2_val;
    end else if (i_sr2 == '0) begin
      sr2_ok  = 1'b1;
    end else if (!busy_full[i_sr2]) begin
      sr2_ok  = 1'b1;
      sr2_val = i_dprf_d2;
    end else if (fwd2_hit) begin
      sr2_ok  = 1'b1;
      sr2_val = fwd2_val;
    end
  end

  assign ready        = i_valid & sr1_ok & sr2_ok;
  assign hazard       = i_valid & ~ready;
  assign advance      = ready & ~i_pipe_stall;
  assign o_pipe_stall = i_pipe_stall | hazard;

  // Opcodes 0x00 and 0x0C write no register, and r0 is never busy.
  always_comb begin
    o_dprf_setbusy = '0;
    if (advance && (i_opcode != 5'h00) && (i_opcode != 5'h0C) && (i_dr != '0))
      o_dprf_setbusy = i_dr;
  end

  // Capture registers. These are loaded only while the instruction is waiting,
  // and cleared when it leaves or is dropped.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_pipe_flush || advance) begin
      cap1_flag <= 1'b0;
      cap2_flag <= 1'b0;
      cap1_val  <= '0;
      cap2_val  <= '0;
    end else if (i_valid) begin
      if (sr1_ok) begin
        cap1_flag <= 1'b1;
        cap1_val  <= sr1_val;
      end
      if (sr2_ok) begin
        cap2_flag <= 1'b1;
        cap2_val  <= sr2_val;
      end
    end
  end

  // Output buffer. Flush takes priority over a downstream stall.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_pipe_flush) begin
      o_valid   <= 1'b0;
      o_opcode  <= '0;
      o_dr      <= '0;
      o_sr1_val <= '0;
      o_sr2_val <= '0;
      o_pc      <= '0;
    end else if (i_pipe_stall) begin
      o_valid   <= o_valid;
    end else if (advance) begin
      o_valid   <= 1'b1;
      o_opcode  <= i_opcode;
      o_dr      <= i_dr;
      o_sr1_val <= sr1_val;
      o_sr2_val <= sr2_val;
      o_pc      <= i_pc;
    end else begin
      o_valid   <= 1'b0;
      o_opcode  <= '0;
      o_dr      <= '0;
      o_sr1_val <= '0;
      o_sr2_val <= '0;
      o_pc      <= '0;
    end
  end

  // The hazard-cycle counter is cleared only by reset, so it survives flushes.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      o_stall_cycles <= '0;
    else if (hazard && (o_stall_cycles != 16'hFFFF))
      o_stall_cycles <= o_stall_cycles + 16'd1;
  end

endmodule

// File: tb/tb_tl45_operand_fetch.sv
module tb_tl45_operand_fetch;

  localparam int XLEN = 32;
  localparam int RW   = 4;

  logic            i_clk, i_reset;
  logic            i_pipe_stall, o_pipe_stall, i_pipe_flush, o_pipe_flush;
  logic            i_valid;
  logic [4:0]      i_opcode;
  logic            i_ri;
  logic [RW-1:0]   i_dr, i_sr1, i_sr2;
  logic [31:0]     i_imm32, i_pc;
  logic [RW-1:0]   o_dprf_read_a1, o_dprf_read_a2;
  logic [31:0]     i_dprf_d1, i_dprf_d2;
  logic [RW-1:0]   o_dprf_setbusy;
  logic [14:0]     i_dprf_busylist;
  logic [1:0]      i_fwd_valid;
  logic [7:0]      i_fwd_reg;
  logic [63:0]     i_fwd_data;
  logic            o_valid;
  logic [4:0]      o_opcode;
  logic [RW-1:0]   o_dr;
  logic [31:0]     o_sr1_val, o_sr2_val, o_pc;
  logic [15:0]     o_stall_cycles;

  tl45_operand_fetch dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_pipe_stall(i_pipe_stall), .o_pipe_stall(o_pipe_stall),
    .i_pipe_flush(i_pipe_flush), .o_pipe_flush(o_pipe_flush),
    .i_valid(i_valid), .i_opcode(i_opcode), .i_ri(i_ri),
    .i_dr(i_dr), .i_sr1(i_sr1), .i_sr2(i_sr2),
    .i_imm32(i_imm32), .i_pc(i_pc),
    .o_dprf_read_a1(o_dprf_read_a1), .o_dprf_read_a2(o_dprf_read_a2),
    .i_dprf_d1(i_dprf_d1), .i_dprf_d2(i_dprf_d2),
    .o_dprf_setbusy(o_dprf_setbusy), .i_dprf_busylist(i_dprf_busylist),
    .i_fwd_valid(i_fwd_valid), .i_fwd_reg(i_fwd_reg), .i_fwd_data(i_fwd_data),
    .o_valid(o_valid), .o_opcode(o_opcode), .o_dr(o_dr),
    .o_sr1_val(o_sr1_val), .o_sr2_val(o_sr2_val), .o_pc(o_pc),
    .o_stall_cycles(o_stall_cycles)
  );

  // ---------------- clock / reset ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, required $finish");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  // Expected output buffer word: {valid, opcode, dr, sr1, sr2, pc}
  localparam int W = 1 + 5 + RW + 32 + 32 + 32;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_prev;
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic v, input logic [4:0] op, input logic [RW-1:0] dr,
                                      input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] pc);
    return {v, op, dr, s1, s2, pc};
  endfunction

  task automatic compare_out();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("o_valid",   {63'd0, o_valid},  {63'd0, e[W-1]});
      check("o_opcode",  {59'd0, o_opcode}, {59'd0, e[W-2 -: 5]});
      check("o_dr",      {60'd0, o_dr},     {60'd0, e[W-7 -: RW]});
      check("o_sr1_val", {32'd0, o_sr1_val}, {32'd0, e[95:64]});
      check("o_sr2_val", {32'd0, o_sr2_val}, {32'd0, e[63:32]});
      check("o_pc",      {32'd0, o_pc},      {32'd0, e[31:0]});
    end
  endtask

  // ---------------- driver tasks ----------------
  // Push the expected output for this cycle, clock it, and compare at edge+1.
  task automatic cycle(input logic [W-1:0] e);
    exp_q.push_back(e);
    exp_prev = e;
    @(posedge i_clk);
    #1;
    compare_out();
  endtask

  task automatic clear_inputs();
    i_reset = 0; i_pipe_stall = 0; i_pipe_flush = 0; i_valid = 0;
    i_opcode = 0; i_ri = 0; i_dr = 0; i_sr1 = 0; i_sr2 = 0;
    i_imm32 = 0; i_pc = 0; i_dprf_d1 = 0; i_dprf_d2 = 0;
    i_dprf_busylist = 0; i_fwd_valid = 0; i_fwd_reg = 0; i_fwd_data = 0;
  endtask

  task automatic set_instr(input logic [4:0] op, input logic [RW-1:0] dr, input logic [RW-1:0] s1,
                           input logic [RW-1:0] s2, input logic [31:0] pc);
    i_valid = 1; i_opcode = op; i_dr = dr; i_sr1 = s1; i_sr2 = s2; i_pc = pc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    exp_stall = 0;
    exp_prev  = '0;

    // Reset
    i_reset = 1;
    @(posedge i_clk); #1;
    cycle('0);
    check("reset_stall_cycles", {48'd0, o_stall_cycles}, 64'd0);
    i_reset = 0;
    #1;
    check("reset_pipe_stall", {63'd0, o_pipe_stall}, 64'd0);
    check("reset_setbusy", {60'd0, o_dprf_setbusy}, 64'd0);

    // No hazard: plain DPRF read
    set_instr(5'h01, 4'd6, 4'd3, 4'd4, 32'h100);
    i_dprf_d1 = 32'h11; i_dprf_d2 = 32'h22;
    #1;
    check("nohaz_setbusy", {60'd0, o_dprf_setbusy}, 64'd6);
    check("nohaz_read_a1", {60'd0, o_dprf_read_a1}, 64'd3);
    check("nohaz_read_a2", {60'd0, o_dprf_read_a2}, 64'd4);
    check("nohaz_pipe_stall", {63'd0, o_pipe_stall}, 64'd0);
    cycle(mk(1'b1, 5'h01, 4'd6, 32'h11, 32'h22, 32'h100));

    // Dual forward priority: bus 0 wins, DPRF data is stale
    set_instr(5'h02, 4'd7, 4'd5, 4'd0, 32'h104);
    i_dprf_d1 = 32'hDEAD;
    i_dprf_busylist = 15'h0010;
    i_fwd_valid = 2'b11; i_fwd_reg = {4'd5, 4'd5}; i_fwd_data = {32'hBB, 32'hAA};
    #1;
    check("fwd_pipe_stall", {63'd0, o_pipe_stall}, 64'd0);
    cycle(mk(1'b1, 5'h02, 4'd7, 32'hAA, 32'h0, 32'h104));
    i_fwd_valid = 2'b10; i_pc = 32'h108;
    cycle(mk(1'b1, 5'h02, 4'd7, 32'hBB, 32'h0, 32'h108));

    // Hazard: r2 busy, no forward, three cycles
    set_instr(5'h01, 4'd3, 4'd2, 4'd0, 32'h10C);
    i_fwd_valid = 0; i_dprf_busylist = 15'h0002;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("haz_pipe_stall", {63'd0, o_pipe_stall}, 64'd1);
      check("haz_setbusy", {60'd0, o_dprf_setbusy}, 64'd0);
      cycle('0);
      exp_stall++;
    end
    check("haz_stall_cycles", {48'd0, o_stall_cycles}, {48'd0, exp_stall});

    // Forward on bus 1 during downstream stall is captured
    i_pipe_stall = 1;
    i_fwd_valid = 2'b10; i_fwd_reg = {4'd2, 4'd0}; i_fwd_data = {32'h55, 32'h0};
    #1;
    check("cap_pipe_stall", {63'd0, o_pipe_stall}, 64'd1);
    cycle(exp_prev);
    check("cap_stall_cycles", {48'd0, o_stall_cycles}, {48'd0, exp_stall});
    i_pipe_stall = 0; i_fwd_valid = 0; i_fwd_data = 0;
    #1;
    check("cap_release_stall", {63'd0, o_pipe_stall}, 64'd0);
    check("cap_setbusy", {60'd0, o_dprf_setbusy}, 64'd3);
    cycle(mk(1'b1, 5'h01, 4'd3, 32'h55, 32'h0, 32'h10C));

    // Immediate mode: busy sr2 is ignored
    set_instr(5'h03, 4'd5, 4'd1, 4'd7, 32'h110);
    i_ri = 1; i_imm32 = 32'h1234; i_dprf_d1 = 32'h77; i_dprf_busylist = 15'h0040;
    #1;
    check("imm_pipe_stall", {63'd0, o_pipe_stall}, 64'd0);
    cycle(mk(1'b1, 5'h03, 4'd5, 32'h77, 32'h1234, 32'h110));
    i_ri = 0; i_dprf_busylist = 0;

    // Flush during downstream stall clears outputs, keeps counter
    i_pipe_stall = 1; i_pipe_flush = 1; i_pc = 32'h114;
    #1;
    check("flush_passthru", {63'd0, o_pipe_flush}, 64'd1);
    cycle('0);
    check("flush_stall_cycles", {48'd0, o_stall_cycles}, {48'd0, exp_stall});
    i_pipe_stall = 0; i_pipe_flush = 0;

    // Setbusy suppression: opcode 0x0C, opcode 0x00, dr = 0
    set_instr(5'h0C, 4'd5, 4'd1, 4'd0, 32'h118);
    #1;
    check("setbusy_op0c", {60'd0, o_dprf_setbusy}, 64'd0);
    cycle(mk(1'b1, 5'h0C, 4'd5, 32'h77, 32'h0, 32'h118));
    i_opcode = 5'h00; i_pc = 32'h11C;
    #1;
    check("setbusy_op00", {60'd0, o_dprf_setbusy}, 64'd0);
    cycle(mk(1'b1, 5'h00, 4'd5, 32'h77, 32'h0, 32'h11C));
    i_opcode = 5'h01; i_dr = 4'd0; i_pc = 32'h120;
    #1;
    check("setbusy_dr0", {60'd0, o_dprf_setbusy}, 64'd0);
    cycle(mk(1'b1, 5'h01, 4'd0, 32'h77, 32'h0, 32'h120));

    // Downstream stall holds the output buffer
    set_instr(5'h04, 4'd9, 4'd1, 4'd0, 32'h124);
    i_pipe_stall = 1;
    #1;
    check("hold_setbusy", {60'd0, o_dprf_setbusy}, 64'd0);
    cycle(exp_prev);
    i_pipe_stall = 0;

    // No instruction -> bubble
    i_valid = 0;
    cycle('0);

    // Capture cleared by flush: the instruction must re-resolve afterwards
    set_instr(5'h01, 4'd8, 4'd2, 4'd0, 32'h128);
    i_dprf_busylist = 15'h0002; i_dprf_d1 = 32'h0;
    i_fwd_valid = 2'b01; i_fwd_reg = {4'd0, 4'd2}; i_fwd_data = {32'h0, 32'h99};
    i_pipe_stall = 1;
    cycle(exp_prev);
    i_pipe_stall = 0; i_pipe_flush = 1; i_fwd_valid = 0;
    cycle('0);
    i_pipe_flush = 0;
    #1;
    check("postflush_pipe_stall", {63'd0, o_pipe_stall}, 64'd1);
    cycle('0);
    exp_stall++;
    check("postflush_stall_cycles", {48'd0, o_stall_cycles}, {48'd0, exp_stall});
    i_dprf_busylist = 0; i_dprf_d1 = 32'h42;
    cycle(mk(1'b1, 5'h01, 4'd8, 32'h42, 32'h0, 32'h128));

    // Saturation: reset, then hold a hazard for 70000 cycles
    i_valid = 0; i_reset = 1;
    cycle('0);
    i_reset = 0;
    check("sat_reset_cnt", {48'd0, o_stall_cycles}, 64'd0);
    set_instr(5'h01, 4'd3, 4'd2, 4'd0, 32'h200);
    i_dprf_busylist = 15'h0002;
    repeat (65534) @(posedge i_clk);
    #1;
    check("sat_fffe", {48'd0, o_stall_cycles}, 64'hFFFE);
    @(posedge i_clk); #1;
    check("sat_ffff", {48'd0, o_stall_cycles}, 64'hFFFF);
    repeat (70000 - 65535) @(posedge i_clk);
    #1;
    check("sat_hold", {48'd0, o_stall_cycles}, 64'hFFFF);
    check("sat_bubble", {63'd0, o_valid}, 64'd0);
    i_reset = 1;
    cycle('0);
    check("sat_after_reset", {48'd0, o_stall_cycles}, 64'd0);
    i_reset = 0;

    check("scoreboard_drained", exp_q.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
